// File: rtl/regfile_write_port_if.sv
// Handshake/bus bundle for the register-file write port.
// REGWR_HAZARD_CHECK_EN adds the chk_addr/chk_hit hazard lookup signals.
interface regfile_write_port_if #(
    parameter int LOG2DEPTH = 2
);
    logic                 in_valid;
    logic [4:0]           in_addr;
    logic [31:0]          in_data;
    logic                 in_ready;
    logic                 drain_en;
    logic [31:0]          wrenable;
    logic [31:0]          wrdata;
    logic                 dropped;
    logic [LOG2DEPTH:0]   level;
    logic                 empty;
`ifdef REGWR_HAZARD_CHECK_EN
    logic [4:0]           chk_addr;
    logic                 chk_hit;

    modport master (
        output in_valid, in_addr, in_data, drain_en, chk_addr,
        input  in_ready, wrenable, wrdata, dropped, level, empty, chk_hit
    );
    modport slave (
        input  in_valid, in_addr, in_data, drain_en, chk_addr,
        output in_ready, wrenable, wrdata, dropped, level, empty, chk_hit
    );
`else
    modport master (
        output in_valid, in_addr, in_data, drain_en,
        input  in_ready, wrenable, wrdata, dropped, level, empty
    );
    modport slave (
        input  in_valid, in_addr, in_data, drain_en,
        output in_ready, wrenable, wrdata, dropped, level, empty
    );
`endif
endinterface

// File: rtl/regfile_write_port.sv
// Write-side controller for the 32x32 register file: FIFO-buffered requests drained into one-hot enables.
// Optional REGWR_HAZARD_CHECK_EN builds the pending-write lookup (chk_addr -> chk_hit).
module regfile_write_port #(
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_port_if.slave   bus
);
    logic [36:0]          r_mem [DEPTH];
    logic [LOG2DEPTH-1:0] r_wptr;
    logic [LOG2DEPTH-1:0] r_rptr;
    logic [LOG2DEPTH:0]   r_level;
    logic [31:0]          r_wrenable_p1;
    logic [31:0]          r_wrdata_p1;
    logic                 r_dropped_p1;

    logic                 w_ready;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [36:0]          w_head;
    logic [4:0]           w_head_addr;

    assign w_ready     = (r_level != (LOG2DEPTH+1)'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_push      = bus.in_valid && w_ready;
    assign w_pop       = bus.drain_en && !w_empty;
    assign w_head      = r_mem[r_rptr];
    assign w_head_addr = w_head[36:32];

    // Queue storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.in_addr, bus.in_data};
        end
    end

    // p0 -> p1: FIFO pop feeds the registered write-enable stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_wrenable_p1 <= '0;
            r_wrdata_p1   <= '0;
            r_dropped_p1  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + (LOG2DEPTH+1)'(w_push) - (LOG2DEPTH+1)'(w_pop);
            if (w_pop) begin
                r_wrenable_p1 <= (w_head_addr != 5'd0) ? (32'd1 << w_head_addr) : 32'd0;
                r_wrdata_p1   <= w_head[31:0];
                r_dropped_p1  <= (w_head_addr == 5'd0);
            end else begin
                r_wrenable_p1 <= '0;
                r_dropped_p1  <= 1'b0;
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.wrenable = r_wrenable_p1;
    assign bus.wrdata   = r_wrdata_p1;
    assign bus.dropped  = r_dropped_p1;

`ifdef REGWR_HAZARD_CHECK_EN
    logic w_chk_hit;

    // Entry k is live when its distance from the read pointer is below level.
    always_comb begin
        w_chk_hit = 1'b0;
        if (bus.chk_addr != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (((LOG2DEPTH+1)'(k) < r_level) &&
                    (r_mem[r_rptr + LOG2DEPTH'(k)][36:32] == bus.chk_addr)) begin
                    w_chk_hit = 1'b1;
                end
            end
            if (r_wrenable_p1[bus.chk_addr]) w_chk_hit = 1'b1;
        end
    end

    assign bus.chk_hit = w_chk_hit;
`endif
endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port against a queue-based reference model.
// Define REGWR_HAZARD_CHECK_EN to also check the chk_hit lookup.
module tb_regfile_write_port;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    regfile_write_port_if #(.LOG2DEPTH(2)) bus ();

    regfile_write_port #(.DEPTH(DEPTH), .LOG2DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [36:0] q[$];
    logic [31:0] e_wren;
    logic [31:0] e_wrdata;
    logic        e_drop;
    logic        inflight;
    logic [4:0]  inflight_addr;
    logic [4:0]  chk_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("wrenable", bus.wrenable, e_wren);
        chk("wrdata", bus.wrdata, e_wrdata);
        chk("dropped", 32'(bus.dropped), 32'(e_drop));
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    endtask

    task automatic model_reset();
        q.delete();
        e_wren = '0; e_wrdata = '0; e_drop = 1'b0; inflight = 1'b0; inflight_addr = '0;
    endtask

    // One clock: drive, check pre-edge combinational outputs, advance model, check registered outputs.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
        logic ready, push, pop;
        logic [36:0] head;
        bus.in_valid = v; bus.in_addr = a; bus.in_data = d; bus.drain_en = dr;
`ifdef REGWR_HAZARD_CHECK_EN
        bus.chk_addr = chk_sel;
`endif
        #1;
        ready = (q.size() != DEPTH);
        chk("in_ready", 32'(bus.in_ready), 32'(ready));
`ifdef REGWR_HAZARD_CHECK_EN
        begin
            logic hit;
            hit = 1'b0;
            if (chk_sel != 0) begin
                foreach (q[i]) if (q[i][36:32] == chk_sel) hit = 1'b1;
                if (inflight && inflight_addr == chk_sel) hit = 1'b1;
            end
            chk("chk_hit", 32'(bus.chk_hit), 32'(hit));
        end
`endif
        @(posedge clk);
        #1;
        pop  = dr && (q.size() != 0);
        push = v && ready;
        if (pop) begin
            head          = q.pop_front();
            e_wren        = (head[36:32] != 0) ? (32'd1 << head[36:32]) : 32'd0;
            e_wrdata      = head[31:0];
            e_drop        = (head[36:32] == 0);
            inflight      = 1'b1;
            inflight_addr = head[36:32];
        end else begin
            e_wren   = '0;
            e_drop   = 1'b0;
            inflight = 1'b0;
        end
        if (push) q.push_back({a, d});
        check_outputs();
    endtask

    initial begin
        chk_sel = 5'd0;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.drain_en = 1'b0;
`ifdef REGWR_HAZARD_CHECK_EN
        bus.chk_addr = '0;
`endif
        model_reset();
        #2;
        check_outputs();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single write to r5
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("single_wren", bus.wrenable, 32'h0000_0020);
        chk("single_data", bus.wrdata, 32'hDEADBEEF);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("single_one_cycle", bus.wrenable, 32'h0);

        // Register 0 is consumed but never enabled
        cycle(1'b1, 5'd0, 32'h12345678, 1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("zero_drop", 32'(bus.dropped), 32'd1);
        chk("zero_wren", bus.wrenable, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("zero_level", 32'(bus.level), 32'd0);

        // Fill with drain held off, then release
        for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 5'd6, 32'h666, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1);
            chk("drain_order", bus.wrenable, 32'd1 << i);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1);

        // Streaming: level steady at 1, pointers wrap
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'(i + 1), $urandom, 1'b1);
        chk("stream_level", 32'(bus.level), 32'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);

        // Same address, arrival order wins
        cycle(1'b1, 5'd7, 32'hA, 1'b1);
        cycle(1'b1, 5'd7, 32'hB, 1'b1);
        chk("same_first", bus.wrdata, 32'hA);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("same_second", bus.wrdata, 32'hB);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);

`ifdef REGWR_HAZARD_CHECK_EN
        chk_sel = 5'd9;
        cycle(1'b1, 5'd9, 32'h99, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0);
        chk("hit_queued", 32'(bus.chk_hit), 32'd1);
        chk_sel = 5'd0;
        cycle(1'b0, 5'd0, 32'h0, 1'b0);
        chk("hit_zero", 32'(bus.chk_hit), 32'd0);
        chk_sel = 5'd9;
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("hit_drained", 32'(bus.chk_hit), 32'd0);
        chk_sel = 5'd0;
`endif

        // Reset mid-queue with a write in flight
        cycle(1'b1, 5'd3, 32'h33, 1'b0);
        cycle(1'b1, 5'd4, 32'h44, 1'b0);
        cycle(1'b1, 5'd5, 32'h55, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1);
        chk("pre_reset_wren", bus.wrenable, 32'h8);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_wren", bus.wrenable, 32'h0);
        chk("async_level", 32'(bus.level), 32'd0);
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_wrdata", bus.wrdata, 32'h0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            chk_sel = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) != 0));
        end
        chk_sel = 5'd0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write-side controller for the 32x32 register file; counterpart of the read muxes.
- Accepts write-back requests (address, data) on a valid/ready handshake and buffers them in a small FIFO.
- Drains one request per cycle into one-hot per-register write enables plus a shared data bus, which feed the 32 register32 instances.
- Writes to register 0 are consumed but never enabled, so register 0 stays hard-wired to zero.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LOG2DEPTH, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  write request present.
- in_addr  input  5  destination register number.
- in_data  input  32  write data.
- in_ready  output  1  FIFO can accept a request this cycle.
- drain_en  input  1  downstream permits a register write this cycle.
- wrenable  output  32  one-hot register write enables, registered.
- wrdata  output  32  data for the asserted wrenable, registered.
- dropped  output  1  one-cycle pulse: a popped entry targeted register 0.
- level  output  LOG2DEPTH+1  current FIFO occupancy, 0..DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Reset (async assert):
  - wrenable=0, wrdata=0, dropped=0, level=0, empty=1.
  - Read and write pointers = 0; in_ready=1 once reset deasserts.
  - A reset asserted mid-operation discards all queued entries, and any in-flight wrenable drops at once.
- Push:
  - Occurs on a posedge where in_valid && in_ready.
  - Stores {in_addr, in_data} at the write pointer; the write pointer wraps modulo DEPTH.
- in_ready = (level != DEPTH). It is combinational from registered level only, never from in_valid or drain_en.
- Pop:
  - Occurs on a posedge where drain_en && !empty.
  - The head entry is removed and the read pointer wraps modulo DEPTH.
- Output register, on every posedge:
  - If pop and head addr != 0: wrenable <= 1<<addr, wrdata <= head data, dropped <= 0.
  - If pop and head addr == 0: wrenable <= 0, wrdata <= head data, dropped <= 1.
  - If no pop: wrenable <= 0, dropped <= 0, wrdata holds its previous value.
- wrenable is always zero or exactly one-hot. It is high for exactly one cycle per popped entry.
- Latency: a request pushed at edge N into an empty FIFO, with drain_en=1, pops at edge N+1. wrenable is visible after edge N+1, so the register captures it at edge N+2. There is no same-cycle fall-through.
- Simultaneous push and pop: both occur and level is unchanged. This is legal at any level < DEPTH.
- When full, in_ready=0 and no push occurs, even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- Ordering: strict FIFO. Two writes to the same address are applied in arrival order, so the last value wins.
- drain_en=0 freezes popping. Pushes continue until full.
- level arithmetic: level_next = level + push - pop, using LOG2DEPTH+1 bits with no overflow. empty is derived from level.

Optional Feature:
- Macro: REGWR_HAZARD_CHECK_EN.
- With the macro defined, the block adds:
  - Input chk_addr[4:0].
  - Output chk_hit (1 bit, combinational): high when any valid FIFO entry, or the entry currently driving wrenable, has addr == chk_addr and chk_addr != 0.
  - The read stage uses chk_hit to stall on a pending write.
- With the macro undefined, neither port exists and no comparators are built.
- Core behaviour is identical in both builds.

Test Plan:
- Reset mid-queue: push 3 entries, assert reset mid-cycle -> level=0, empty=1, wrenable=0 immediately (before the next clk edge), no later writes emitted.
- Single write: in_addr=5, in_data=0xDEADBEEF, drain_en=1 -> one cycle later wrenable=0x00000020, wrdata=0xDEADBEEF for exactly 1 cycle, dropped=0.
- Zero register: in_addr=0, in_data=0x12345678 -> wrenable stays 0, dropped pulses 1 cycle, level returns to 0.
- Fill and backpressure: drain_en=0, push addrs 1,2,3,4 (DEPTH=4):
  - After the fills, level=4 and in_ready=0; a 5th in_valid is ignored.
  - Raise drain_en -> wrenable sequence 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
  - in_ready returns to 1 one cycle after the first pop.
- Streaming and same-address order:
  - Push every cycle with drain_en=1 -> level steady at 1, wrenable one-hot every cycle, pointers wrap past DEPTH with no loss.
  - Two writes to addr 7 with 0xA then 0xB -> wrdata order 0xA, 0xB.
- Hazard check (REGWR_HAZARD_CHECK_EN):
  - Queue addr 9 with drain_en=0, chk_addr=9 -> chk_hit=1.
  - chk_addr=0 -> chk_hit=0.
  - After the drain completes and wrenable returns to 0 -> chk_hit=0.
